// File: rtl/mem_controller.sv
// Memory controller: held CPU request -> wait states -> RAM read/write, RMW for sub-word stores.
// Optional bounds checking is enabled by defining MEM_CTRL_BOUNDS_EN.
module mem_controller #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned MEM_WORDS   = 128
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_write,
    input  logic [15:31] cpu_address,
    input  logic [0:3]   cpu_byte_en,
    input  logic [0:31]  cpu_data_in,
    output logic [0:31]  cpu_data_out,
    output logic         cpu_ready,
    output logic         cpu_fault,
    output logic [15:31] ram_address,
    output logic         ram_write_en,
    output logic [0:31]  ram_data_out,
    input  logic [0:31]  ram_data_in
);

    typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_t;

    localparam logic [15:31] ADDR_MASK = 17'(MEM_WORDS - 1);
    localparam logic [3:0]   WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic        lat_write;
    logic [0:3]  lat_be;
    logic [0:31] merged;
    logic        out_of_range;

`ifdef MEM_CTRL_BOUNDS_EN
    logic fault_q;
    assign out_of_range = 32'(cpu_address) >= MEM_WORDS;
    assign cpu_fault    = (state == DONE) && fault_q;
`else
    assign out_of_range = 1'b0;
    assign cpu_fault    = 1'b0;
`endif

    // Both strobes come straight from the state register, so reset removes them at once.
    assign cpu_ready    = (state == DONE);
    assign ram_write_en = (state == WRITE);

    function automatic state_t access_state(input logic write, input logic [0:3] be);
        if (!write)             return READ;
        else if (be == 4'b1111) return WRITE;
        else if (be == 4'b0000) return DONE;
        else                    return READ;
    endfunction

    // ram_data_out holds the CPU store data until READ replaces it with the merged word.
    always_comb begin
        merged = ram_data_in;
        for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) merged[8*i +: 8] = ram_data_out[8*i +: 8];
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (out_of_range)          state_next = DONE;
                    else if (WAIT_STATES == 0) state_next = access_state(cpu_write, cpu_byte_en);
                    else                       state_next = WAIT;
                end
            end
            WAIT:    if (wait_cnt == WAIT_LAST) state_next = access_state(lat_write, lat_be);
            READ:    state_next = lat_write ? WRITE : DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            lat_write    <= 1'b0;
            lat_be       <= 4'b0000;
            cpu_data_out <= '0;
            ram_address  <= '0;
            ram_data_out <= '0;
`ifdef MEM_CTRL_BOUNDS_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        ram_address  <= cpu_address & ADDR_MASK;
                        lat_write    <= cpu_write;
                        lat_be       <= cpu_byte_en;
                        ram_data_out <= cpu_data_in;
                        wait_cnt     <= 4'd0;
`ifdef MEM_CTRL_BOUNDS_EN
                        fault_q      <= out_of_range;
`endif
                    end
                end
                WAIT: wait_cnt <= wait_cnt + 4'd1;
                READ: begin
                    if (lat_write) ram_data_out <= merged;
                    else           cpu_data_out <= ram_data_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_controller.md
# mem_controller

Memory controller sitting between the microcoded CPU's memory port and the word-wide RAM model. It turns a held CPU request into RAM cycles, inserts a fixed number of wait states, and returns data with a one-cycle ready pulse. Byte and halfword stores run as read-modify-write, because the RAM only writes whole words. An optional bounds checker faults out-of-range addresses instead of letting them wrap.

## Interface
Parameters:
- WAIT_STATES, 1, idle cycles inserted before every RAM access (0–15)
- MEM_WORDS, 128, RAM size in words; power of two

Ports:
- clock  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low; controller held in IDLE while low
- cpu_req  in  1  request; held high until cpu_ready is sampled high
- cpu_write  in  1  1 = store, 0 = fetch
- cpu_address  in  17 [15:31]  word address
- cpu_byte_en  in  4  store lane enables; bit 0 = bits [0:7] (big-endian)
- cpu_data_in  in  32  store data
- cpu_data_out  out  32  fetch data; valid while cpu_ready is high
- cpu_ready  out  1  one-cycle completion pulse
- cpu_fault  out  1  one-cycle pulse with cpu_ready on an out-of-range access
- ram_address  out  17  registered copy of the accepted address
- ram_write_en  out  1  RAM write strobe; the RAM commits on the rising edge while it is high
- ram_data_out  out  32  write data to RAM
- ram_data_in  in  32  combinational RAM read data

## Operation
- States: IDLE, WAIT, READ, WRITE, DONE.
- IDLE with cpu_req=1: latch address, write, byte_en and data. Go to WAIT, or skip WAIT when WAIT_STATES=0.
- WAIT: a 4-bit counter counts WAIT_STATES cycles, then:
  - fetch → READ
  - full store (byte_en=4'b1111) → WRITE
  - partial store (0 < byte_en < 4'b1111) → READ
  - null store (byte_en=4'b0000) → DONE
- READ, fetch: capture ram_data_in into cpu_data_out, then → DONE.
- READ, partial store: build the merged word (enabled lanes from CPU data, other lanes from ram_data_in) into ram_data_out, then → WRITE.
- WRITE: ram_write_en=1 for exactly one cycle, then → DONE.
- DONE: cpu_ready=1 for one cycle, then → IDLE.
- The requester drops cpu_req on the edge that samples cpu_ready. If cpu_req is still high in IDLE, it is accepted as a new request.
- ram_write_en is decoded from the state register only and is never asserted outside WRITE.
- cpu_data_out holds its last fetched value until the next fetch completes.

## Timing
- E0 = the edge on which IDLE accepts a request. Let W = WAIT_STATES.
- cpu_ready rises at:
  - fetch: E0+W+2
  - full store: E0+W+2
  - null store: E0+W+1
  - partial store: E0+W+3
- For a full store, the RAM commits at E0+W+2.
- Minimum spacing between back-to-back requests is one IDLE cycle.
- Reset values: cpu_data_out=0, cpu_ready=0, cpu_fault=0, ram_address=0, ram_write_en=0, ram_data_out=0, state IDLE, wait counter 0.
- Reset asserted mid-operation:
  - Returns to IDLE immediately, without waiting for an edge.
  - ram_write_en drops immediately.
  - No ready pulse is issued, and the aborted request is discarded.
  - A read-modify-write aborted before WRITE leaves RAM unchanged.

## Configuration
- MEM_CTRL_BOUNDS_EN defined:
  - A request with cpu_address ≥ MEM_WORDS goes IDLE → DONE.
  - cpu_ready and cpu_fault pulse together at E0+1, ignoring WAIT_STATES.
  - No RAM write occurs, and cpu_data_out is unchanged.
- MEM_CTRL_BOUNDS_EN undefined:
  - ram_address = cpu_address & (MEM_WORDS-1), so out-of-range addresses wrap.
  - cpu_fault is tied to 0.

## Test plan
- Reset, WAIT_STATES=1: release reset; fetch address 0x05 whose RAM word is 0x12345678 → cpu_ready at E0+3, cpu_data_out=0x12345678, cpu_fault=0.
- Full store, WAIT_STATES=0: store 0xDEADBEEF to 0x10 with byte_en=4'b1111 → ram_write_en high for one cycle, ready at E0+2; a following fetch of 0x10 returns 0xDEADBEEF.
- Partial store: RAM[0x20]=0x11223344, store 0xAABBCCDD with byte_en=4'b0110 → RAM[0x20]=0x11BBCC44, ready at E0+W+3; null store with byte_en=4'b0000 → no ram_write_en, ready at E0+W+1.
- Back-to-back: hold cpu_req across the ready edge → second request accepted after one IDLE cycle; exactly two ready pulses.
- Reset mid-RMW: assert reset during READ of a partial store to 0x20 → outputs zero immediately, RAM[0x20] unchanged, no ready pulse.
- Bounds: with MEM_CTRL_BOUNDS_EN, fetch 0x80 (MEM_WORDS=128) → ready and fault at E0+1. Without the macro, a store to 0x80 writes RAM[0x00] and cpu_fault stays 0.
